// File: rtl/dut_param_pkg.sv
// rtl/dut_param_pkg.sv - shared constants for the parametrised counter / shift-register block
package dut_param_pkg;

    localparam logic DIR_UP      = 1'b0;
    localparam logic DIR_DN      = 1'b1;
    localparam int   MODE_WRAP   = 0;
    localparam int   MODE_SAT    = 1;
    localparam int   MATCH_CNT_W = 8;

endpackage

// File: rtl/dut_chan_counter.sv
// rtl/dut_chan_counter.sv - one up/down counter channel with load, wrap/saturate and terminal-count pulse
//
// Ports:
//  clk, reset  clock and synchronous active-high reset
//  en          count enable (ignored while load is set)
//  dir         DIR_UP / DIR_DN
//  load        synchronous load strobe, highest priority after reset
//  load_val    value captured on load
//  cnt         counter value
//  tc          registered terminal-count pulse: high after a wrapping step or a step blocked at a limit
module dut_chan_counter
    import dut_param_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int SAT_MODE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MIN = '0;
    localparam logic             IS_SAT  = (SAT_MODE == MODE_SAT);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            tc  <= 1'b0;
        end else if (load) begin
            cnt <= load_val;
            tc  <= 1'b0;
        end else if (en) begin
            if (dir == DIR_UP) begin
                if (cnt == CNT_MAX) begin
                    // Limit reached: either wrap to zero or stay put; tc flags both cases.
                    tc  <= 1'b1;
                    cnt <= IS_SAT ? CNT_MAX : CNT_MIN;
                end else begin
                    tc  <= 1'b0;
                    cnt <= cnt + 1'b1;
                end
            end else begin
                if (cnt == CNT_MIN) begin
                    tc  <= 1'b1;
                    cnt <= IS_SAT ? CNT_MIN : CNT_MAX;
                end else begin
                    tc  <= 1'b0;
                    cnt <= cnt - 1'b1;
                end
            end
        end else begin
            tc <= 1'b0;
        end
    end

endmodule

// File: rtl/dut_param_counter_sr.sv
// rtl/dut_param_counter_sr.sv - NUM_CNT counter channels plus serial shift register with pattern detector
//
// Ports:
//  clk, reset  clock and synchronous active-high reset
//  a           serial data in; q is a delayed one clock
//  b           shared count direction (0 up, 1 down)
//  cnt_en      per-channel count enable
//  load        per-channel load strobe; load_val goes to every selected channel
//  cnt         channel i at [i*CNT_W +: CNT_W]
//  tc          per-channel terminal-count pulse
//  sr          shift register, newest bit in [0]
//  match       registered pattern match, qualified by shift-register fill
//  match_cnt   saturating count of clocks with match high
module dut_param_counter_sr
    import dut_param_pkg::*;
#(
    parameter int                     CNT_W    = 16,
    parameter int                     NUM_CNT  = 2,
    parameter int                     SR_DEPTH = 4,
    parameter int                     SAT_MODE = MODE_WRAP,
    parameter logic [SR_DEPTH-1:0]    PATTERN  = 4'b1011
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        a,
    input  logic                        b,
    input  logic [NUM_CNT-1:0]          cnt_en,
    input  logic [NUM_CNT-1:0]          load,
    input  logic [CNT_W-1:0]            load_val,
    output logic                        q,
    output logic [NUM_CNT*CNT_W-1:0]    cnt,
    output logic [NUM_CNT-1:0]          tc,
    output logic [SR_DEPTH-1:0]         sr,
    output logic                        match,
    output logic [MATCH_CNT_W-1:0]      match_cnt
);

    localparam int                FILL_W   = $clog2(SR_DEPTH + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SR_DEPTH);
    localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(SR_DEPTH - 1);

    logic [FILL_W-1:0]   fill;
    logic [SR_DEPTH-1:0] sr_next;

    assign sr_next = {sr[SR_DEPTH-2:0], a};

    genvar i;
    generate
        for (i = 0; i < NUM_CNT; i++) begin : g_chan
            dut_chan_counter #(
                .CNT_W    (CNT_W),
                .SAT_MODE (SAT_MODE)
            ) u_chan (
                .clk      (clk),
                .reset    (reset),
                .en       (cnt_en[i]),
                .dir      (b),
                .load     (load[i]),
                .load_val (load_val),
                .cnt      (cnt[i*CNT_W +: CNT_W]),
                .tc       (tc[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            q         <= 1'b0;
            sr        <= '0;
            fill      <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
        end else begin
            q  <= a;
            sr <= sr_next;
            if (fill != FILL_MAX) begin
                fill <= fill + 1'b1;
            end
            // Compare against the value sr takes on this edge so match lines up with sr.
            // The fill check keeps stale reset zeros from matching an all-zero pattern.
            match <= (sr_next == PATTERN) && (fill >= FILL_ARM);
            if (match && (match_cnt != '1)) begin
                match_cnt <= match_cnt + 1'b1;
            end
        end
    end

endmodule
